// File: rtl/seven_seg_display_ctrl.sv
// rtl/seven_seg_display_ctrl.sv - 4-digit multiplexed seven-segment display sequencer
//
// Purpose:
//    Divides clk into per-digit refresh ticks and rotates the active digit
//    rightmost-first. It drives registered, hex-decoded, active-low segments
//    for the selected digit. Display values arrive over a valid/ready
//    handshake into a pending buffer. They are copied to the active buffer
//    only at frame boundaries, or at once while the scan is disabled.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//    When defined, leading-zero digits 3..1 are blanked.
//
// Ports:
//    clk         in   1   system clock, rising edge
//    reset       in   1   asynchronous, active-high reset
//    enable      in   1   1 = scan display, 0 = blank display and hold scan at slot 0
//    load_valid  in   1   new display value offered
//    load_ready  out  1   pending buffer empty
//    load_data   in   16  four hex nibbles, [3:0] = rightmost digit
//    load_dp     in   4   decimal points, bit i = digit i, 1 = lit
//    anode       out  4   active-low digit enables, bit 0 = rightmost digit
//    seg         out  7   active-low segments {g,f,e,d,c,b,a}
//    dp          out  1   active-low decimal point
//    frame_done  out  1   one-cycle pulse on the slot 3 -> slot 0 tick

module seven_seg_display_ctrl #(
   parameter int REFRESH_DIV = 100000,
   parameter int DIV_W       = 17
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] load_data,
   input  logic [3:0]  load_dp,
   output logic [3:0]  anode,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   logic [DIV_W-1:0] presc;
   logic [1:0]       slot;
   logic [15:0]      act_data;
   logic [3:0]       act_dp;
   logic [15:0]      pend_data;
   logic [3:0]       pend_dp;
   logic             pend_full;

   logic             tick;
   logic             wrap;
   logic             commit;
   logic             xfer;
   logic [3:0]       cur_nib;
   logic             cur_dp;
   logic             blank;

   assign tick       = enable && (presc == DIV_W'(REFRESH_DIV - 1));
   assign wrap       = tick && (slot == 2'd3);
   assign frame_done = wrap;
   assign load_ready = ~pend_full;

   // With the scan stopped there is no frame to tear, so pending goes
   // straight through on the cycle after capture.
   assign commit = pend_full && (enable ? wrap : 1'b1);

   // A capture only happens into an empty buffer, and a commit only
   // happens from a full one. A transfer on a slot-3 tick therefore waits
   // for the next boundary.
   assign xfer = load_valid && ~pend_full;

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 7'h40;
         4'h1: hex_seg = 7'h79;
         4'h2: hex_seg = 7'h24;
         4'h3: hex_seg = 7'h30;
         4'h4: hex_seg = 7'h19;
         4'h5: hex_seg = 7'h12;
         4'h6: hex_seg = 7'h02;
         4'h7: hex_seg = 7'h78;
         4'h8: hex_seg = 7'h00;
         4'h9: hex_seg = 7'h10;
         4'hA: hex_seg = 7'h08;
         4'hB: hex_seg = 7'h03;
         4'hC: hex_seg = 7'h46;
         4'hD: hex_seg = 7'h21;
         4'hE: hex_seg = 7'h06;
         default: hex_seg = 7'h0E;
      endcase
   endfunction

   always_comb begin
      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      case (slot)
         2'd0: begin cur_nib = act_data[3:0];   cur_dp = act_dp[0]; end
         2'd1: begin cur_nib = act_data[7:4];   cur_dp = act_dp[1]; end
         2'd2: begin cur_nib = act_data[11:8];  cur_dp = act_dp[2]; end
         default: begin cur_nib = act_data[15:12]; cur_dp = act_dp[3]; end
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every more-significant nibble are 0.
   logic zero3;
   logic zero2;
   logic zero1;
   assign zero3 = (act_data[15:12] == 4'h0);
   assign zero2 = zero3 && (act_data[11:8] == 4'h0);
   assign zero1 = zero2 && (act_data[7:4] == 4'h0);

   always_comb begin
      blank = 1'b0;
      case (slot)
         2'd1: blank = zero1;
         2'd2: blank = zero2;
         2'd3: blank = zero3;
         default: blank = 1'b0;
      endcase
   end
`else
   assign blank = 1'b0;
`endif

   // Prescaler and slot counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
         slot  <= 2'd0;
      end else if (!enable) begin
         presc <= '0;
         slot  <= 2'd0;
      end else if (tick) begin
         presc <= '0;
         slot  <= slot + 2'd1;
      end else begin
         presc <= presc + DIV_W'(1);
      end
   end

   // Pending and active buffers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_full <= 1'b0;
         pend_data <= 16'h0000;
         pend_dp   <= 4'h0;
         act_data  <= 16'h0000;
         act_dp    <= 4'h0;
      end else if (commit) begin
         act_data  <= pend_data;
         act_dp    <= pend_dp;
         pend_full <= 1'b0;
      end else if (xfer) begin
         pend_data <= load_data;
         pend_dp   <= load_dp;
         pend_full <= 1'b1;
      end
   end

   // Registered display drive: one cycle behind slot and active value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         anode <= 4'hF;
         seg   <= 7'h7F;
         dp    <= 1'b1;
      end else if (!enable || blank) begin
         anode <= 4'hF;
         seg   <= 7'h7F;
         dp    <= 1'b1;
      end else begin
         anode <= ~(4'b0001 << slot);
         seg   <= hex_seg(cur_nib);
         dp    <= ~cur_dp;
      end
   end

endmodule
